// File: rtl/crc_frame_checker.sv
// -----------------------------------------------------------------------------
// crc_frame_checker
//   Receive-side CRC-32 (reflected, byte-wise) frame checker. Every accepted
//   byte, including the 4 trailing FCS bytes, is folded into the CRC register.
//   A 4-byte holdback line delays the stream so that the FCS is never
//   forwarded. One status strobe is issued per frame, in the cycle after the
//   s_last byte is accepted.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   s_valid/s_ready      input byte handshake; s_data byte, s_last = last FCS byte
//   m_valid/m_ready      payload handshake; m_data byte, m_last = last payload byte
//   st_valid             one-cycle status strobe per frame
//   st_ok, st_runt       frame good / frame had <= 4 bytes
//   st_len               bytes received incl. FCS (saturating)
//   st_crc               CRC register value at end of frame
// -----------------------------------------------------------------------------
module crc_frame_checker #(
  parameter logic [31:0] POLY    = 32'hEDB88320,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE = 32'hDEBB20E3,
  parameter int          LEN_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic             m_last,
  output logic             st_valid,
  output logic             st_ok,
  output logic             st_runt,
  output logic [LEN_W-1:0] st_len,
  output logic [31:0]      st_crc
);

  typedef enum logic {RUN, DONE} state_t;

  state_t           r_state;
  logic [31:0]      r_crc;
  logic [2:0]       r_fill;
  logic [LEN_W-1:0] r_len;
  logic [7:0]       r_hold [4];
  logic             r_st_valid;
  logic             r_st_ok;
  logic             r_st_runt;
  logic [LEN_W-1:0] r_st_len;
  logic [31:0]      r_st_crc;

  logic             w_run;
  logic             w_full;
  logic             w_accept;
  logic [31:0]      w_crc_next;
  logic [LEN_W-1:0] w_len_next;
  logic             w_runt_next;

  // One reflected CRC byte step: fold the byte into the low bits, then eight
  // LSB-first shift/conditional-XOR iterations.
  // NOTE: blocking assignments are correct here -- this is pure combinational
  // math on a local variable, evaluated in order within one call.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Ready is held low while reset is asserted so nothing is taken mid-reset.
  assign w_run    = (r_state == RUN) & ~rst;
  assign w_full   = (r_fill == 3'd4);
  assign s_ready  = w_run & (~w_full | m_ready);
  assign w_accept = s_valid & s_ready;

  // With the line full, the incoming byte and the outgoing oldest byte move in
  // the same transfer, so the downstream stall propagates straight to s_ready.
  assign m_valid  = w_run & s_valid & w_full;
  assign m_data   = r_hold[0];
  assign m_last   = m_valid & s_last;

  assign w_crc_next  = crc_byte(r_crc, s_data);
  assign w_len_next  = (&r_len) ? r_len : r_len + LEN_W'(1);
  assign w_runt_next = (w_len_next <= LEN_W'(4));

  assign st_valid = r_st_valid;
  assign st_ok    = r_st_ok;
  assign st_runt  = r_st_runt;
  assign st_len   = r_st_len;
  assign st_crc   = r_st_crc;

  // NOTE: the holdback bytes carry no reset -- r_fill alone says which entries
  // are meaningful, so clearing the storage would only cost reset routing.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (w_full) begin
        for (int i = 0; i < 3; i++) r_hold[i] <= r_hold[i+1];
        r_hold[3] <= s_data;
      end else begin
        r_hold[r_fill[1:0]] <= s_data;
      end
    end
  end

  // NOTE: every register in this block uses non-blocking assignment so all
  // state updates see the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_crc      <= INIT;
      r_fill     <= 3'd0;
      r_len      <= '0;
      r_st_valid <= 1'b0;
      r_st_ok    <= 1'b0;
      r_st_runt  <= 1'b0;
      r_st_len   <= '0;
      r_st_crc   <= 32'h0;
    end else begin
      r_st_valid <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_accept) begin
            r_crc <= w_crc_next;
            r_len <= w_len_next;
            if (!w_full) r_fill <= r_fill + 3'd1;
            if (s_last) begin
              r_state    <= DONE;
              r_st_valid <= 1'b1;
              r_st_crc   <= w_crc_next;
              r_st_len   <= w_len_next;
              r_st_runt  <= w_runt_next;
              r_st_ok    <= (w_crc_next == RESIDUE) & ~w_runt_next;
            end
          end
        end
        DONE: begin
          // Bytes still in the line are the FCS; drop them.
          r_state <= RUN;
          r_fill  <= 3'd0;
          r_crc   <= INIT;
          r_len   <= '0;
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_frame_checker.sv
module tb_crc_frame_checker;

  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef logic [7:0] byte_q_t [$];
  typedef struct packed { logic [7:0] d; logic l; } beat_t;
  typedef struct packed { logic ok; logic runt; logic [15:0] len; logic [31:0] crc; } stat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [7:0]  m_data;
  logic        m_last;
  logic        st_valid;
  logic        st_ok;
  logic        st_runt;
  logic [15:0] st_len;
  logic [31:0] st_crc;

  int total = 0;
  int bad   = 0;

  beat_t m_q [$];
  stat_t st_q [$];
  logic  prev_st = 1'b0;

  crc_frame_checker dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .st_valid(st_valid), .st_ok(st_ok), .st_runt(st_runt),
    .st_len(st_len), .st_crc(st_crc)
  );

  always #5 clk = ~clk;

  // Bit-serial reference CRC: one polynomial step per data bit, LSB first.
  function automatic logic [31:0] model_crc(input byte_q_t f);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (f[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ f[i][b];
        c  = c >> 1;
        if (fb) c = c ^ POLY;
      end
    end
    return c;
  endfunction

  function automatic void expect_payload(input byte_q_t f);
    beat_t bt;
    for (int i = 0; i < f.size() - 4; i++) begin
      bt.d = f[i];
      bt.l = (i == f.size() - 5);
      m_q.push_back(bt);
    end
  endfunction

  function automatic void expect_status_model(input byte_q_t f);
    stat_t s;
    s.crc  = model_crc(f);
    s.len  = 16'(f.size());
    s.runt = (f.size() <= 4);
    s.ok   = (s.crc == RESIDUE) && !s.runt;
    st_q.push_back(s);
  endfunction

  // Scoreboard monitor: sampled on the falling edge, between input updates.
  always @(negedge clk) begin
    beat_t bt;
    stat_t s;
    if (m_valid && m_ready) begin
      total++;
      if (m_q.size() == 0) begin
        bad++;
        $display("FAIL m_beat unexpected: got data=%h last=%b, none expected", m_data, m_last);
      end else begin
        bt = m_q.pop_front();
        if ({m_data, m_last} !== bt) begin
          bad++;
          $display("FAIL m_beat: got data=%h last=%b, want data=%h last=%b", m_data, m_last, bt.d, bt.l);
        end
      end
    end
    if (!m_valid && m_last) begin
      total++;
      bad++;
      $display("FAIL m_last_without_valid: got m_last=1 with m_valid=0");
    end
    if (st_valid) begin
      total++;
      if (prev_st) begin
        bad++;
        $display("FAIL st_valid_width: got strobe high two cycles running, want one");
      end
      if (st_q.size() == 0) begin
        bad++;
        $display("FAIL status unexpected: got ok=%b runt=%b len=%0d crc=%h", st_ok, st_runt, st_len, st_crc);
      end else begin
        s = st_q.pop_front();
        if ({st_ok, st_runt, st_len, st_crc} !== s) begin
          bad++;
          $display("FAIL status: got ok=%b runt=%b len=%0d crc=%h, want ok=%b runt=%b len=%0d crc=%h",
                   st_ok, st_runt, st_len, st_crc, s.ok, s.runt, s.len, s.crc);
        end
      end
    end
    prev_st = st_valid;
  end

  // Drive bytes of one frame; rnd adds s_valid gaps and random m_ready,
  // chk verifies the s_ready rule against a local holdback fill count.
  task automatic drive(input byte_q_t f, input bit with_last, input bit rnd, input bit chk,
                       output int first_wait);
    int  i      = 0;
    int  fill   = 0;
    int  cycles = 0;
    bit  acc;
    first_wait = 0;
    if (!rnd) m_ready = 1'b1;
    while (i < f.size()) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      if (rnd && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end else begin
        s_valid = 1'b1;
        s_data  = f[i];
        s_last  = with_last && (i == f.size() - 1);
      end
      @(negedge clk);
      acc = s_valid && s_ready;
      if (chk && i > 0) begin
        total++;
        if (s_ready !== ((fill < 4) || m_ready)) begin
          bad++;
          $display("FAIL s_ready_rule: got %b, want %b (fill=%0d m_ready=%b)",
                   s_ready, ((fill < 4) || m_ready), fill, m_ready);
        end
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (fill < 4) fill++;
        i++;
      end else if (i == 0 && s_valid) begin
        first_wait++;
      end
      cycles++;
      if (cycles > 2000) begin
        total++;
        bad++;
        $display("FAIL drive_timeout: got %0d bytes accepted, want %0d", i, f.size());
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic byte_q_t good_frame();
    byte_q_t f;
    f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
          8'h26, 8'h39, 8'hF4, 8'hCB};
    return f;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({s_ready, m_valid, m_last, st_valid, st_ok, st_runt} !== 6'b0 || st_len !== 16'h0 || st_crc !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b mv=%b ml=%b sv=%b ok=%b runt=%b len=%0d crc=%h, want all 0",
               s_ready, m_valid, m_last, st_valid, st_ok, st_runt, st_len, st_crc);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: got s_ready=%b m_valid=%b, want 1 0", s_ready, m_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_good_frame();
    byte_q_t f;
    stat_t   s;
    int      fw;
    f = good_frame();
    expect_payload(f);
    s.ok = 1'b1; s.runt = 1'b0; s.len = 16'd13; s.crc = 32'hDEBB20E3;
    st_q.push_back(s);
    drive(f, 1'b1, 1'b0, 1'b1, fw);
    idle(4);
  endtask

  task automatic test_bad_crc();
    byte_q_t f;
    int      fw;
    f = good_frame();
    f[4] = f[4] ^ 8'h01;
    expect_payload(f);
    expect_status_model(f);
    drive(f, 1'b1, 1'b0, 1'b0, fw);
    idle(2);
    total++;
    if (st_ok !== 1'b0 || st_runt !== 1'b0 || st_len !== 16'd13 || st_crc === RESIDUE) begin
      bad++;
      $display("FAIL bad_crc_hold: got ok=%b runt=%b len=%0d crc=%h, want ok=0 runt=0 len=13 crc!=%h",
               st_ok, st_runt, st_len, st_crc, RESIDUE);
    end
    idle(2);
  endtask

  task automatic test_runt();
    byte_q_t f;
    int      fw;
    f = '{8'hAA, 8'hBB, 8'hCC};
    expect_status_model(f);
    drive(f, 1'b1, 1'b0, 1'b0, fw);
    idle(3);
    f = good_frame();
    expect_payload(f);
    expect_status_model(f);
    drive(f, 1'b1, 1'b0, 1'b0, fw);
    idle(4);
  endtask

  task automatic test_min_frame();
    byte_q_t f;
    int      fw;
    f = '{8'h5A, 8'h01, 8'h02, 8'h03, 8'h04};
    expect_payload(f);
    expect_status_model(f);
    drive(f, 1'b1, 1'b0, 1'b0, fw);
    idle(4);
  endtask

  task automatic test_stall();
    byte_q_t f;
    int      fw;
    f = good_frame();
    for (int r = 0; r < 3; r++) begin
      expect_payload(f);
      expect_status_model(f);
      drive(f, 1'b1, 1'b1, 1'b1, fw);
      idle(3);
    end
  endtask

  task automatic test_abort();
    byte_q_t f;
    byte_q_t part;
    beat_t   bt;
    int      fw;
    f = good_frame();
    for (int i = 0; i < 6; i++) part.push_back(f[i]);
    // With the line full after 4 bytes, bytes 5 and 6 push out 31 and 32.
    bt.l = 1'b0;
    bt.d = 8'h31; m_q.push_back(bt);
    bt.d = 8'h32; m_q.push_back(bt);
    drive(part, 1'b0, 1'b0, 1'b0, fw);
    s_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || st_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_in_reset: got rdy=%b mv=%b sv=%b, want 0 0 0", s_ready, m_valid, st_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    expect_payload(f);
    expect_status_model(f);
    drive(f, 1'b1, 1'b0, 1'b0, fw);
    idle(4);
  endtask

  task automatic test_back_to_back();
    byte_q_t f;
    int      fw1, fw2;
    f = good_frame();
    expect_payload(f);
    expect_status_model(f);
    expect_payload(f);
    expect_status_model(f);
    drive(f, 1'b1, 1'b0, 1'b1, fw1);
    drive(f, 1'b1, 1'b0, 1'b1, fw2);
    total++;
    if (fw2 !== 1) begin
      bad++;
      $display("FAIL back_to_back_bubble: got %0d stall cycles, want 1", fw2);
    end
    idle(4);
  endtask

  task automatic test_drain();
    total++;
    if (m_q.size() != 0 || st_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d beats and %0d statuses left, want 0 0",
               m_q.size(), st_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_runt();
    test_min_frame();
    test_stall();
    test_abort();
    test_back_to_back();
    idle(10);
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
